// File: rtl/mux_nway_reg.sv
// Purpose : selects one of NUM_IN valid/ready source channels (fixed index or
//           round-robin) into a single registered output stage.
// Latency : one cycle from accepted input to out_valid; one word per cycle.
// Backpr. : out_valid && !out_ready holds the output register and drops every in_ready.
//
// Ports:
//   clk, rst_n          clock (rising edge) / asynchronous active-low reset
//   mode, sel           0 = fixed select using sel, 1 = round-robin
//   in_data/in_valid    packed channel data (channel i at [i*WIDTH +: WIDTH]) and valids
//   in_ready            per-channel ready, one-hot or zero
//   out_data/out_src    registered word and index of the channel it came from
//   out_valid/out_ready output handshake
module mux_nway_reg #(
   parameter int WIDTH  = 16,
   parameter int NUM_IN = 3,
   parameter int SEL_W  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_src,
   output logic                    out_valid,
   input  logic                    out_ready
);

   logic [SEL_W-1:0]  rr_ptr;
   logic [SEL_W-1:0]  grant_idx;
   logic              grant_vld;
   logic              load_en;
   logic [NUM_IN-1:0] rot_vld;
   logic [SEL_W:0]    rr_sum;
   logic [WIDTH-1:0]  grant_dat;

   // The register can take a new word when empty or when its word leaves this cycle.
   assign load_en = !out_valid || out_ready;

   // Valids rotated so that bit k corresponds to channel (rr_ptr + k) mod NUM_IN.
   assign rot_vld = NUM_IN'({in_valid, in_valid} >> rr_ptr);

   always_comb begin
      grant_idx = '0;
      grant_vld = 1'b0;
      rr_sum    = '0;
      if (!mode) begin
         // Out-of-range select falls back to the last input, as the old mux did.
         if ({1'b0, sel} >= (SEL_W+1)'(NUM_IN))
            grant_idx = SEL_W'(NUM_IN-1);
         else
            grant_idx = sel;
         for (int i = 0; i < NUM_IN; i++) begin
            if (grant_idx == SEL_W'(i))
               grant_vld = in_valid[i];
         end
      end else begin
         // Walk from the farthest offset down so the nearest valid channel wins.
         for (int k = NUM_IN-1; k >= 0; k--) begin
            if (rot_vld[k]) begin
               rr_sum = {1'b0, rr_ptr} + (SEL_W+1)'(k);
               if (rr_sum >= (SEL_W+1)'(NUM_IN))
                  rr_sum = rr_sum - (SEL_W+1)'(NUM_IN);
               grant_idx = rr_sum[SEL_W-1:0];
               grant_vld = 1'b1;
            end
         end
      end
   end

   always_comb begin
      grant_dat = '0;
      in_ready  = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant_idx == SEL_W'(i)) begin
            grant_dat   = in_data[i*WIDTH +: WIDTH];
            in_ready[i] = rst_n && load_en && grant_vld;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         rr_ptr    <= '0;
      end else if (load_en) begin
         if (grant_vld) begin
            out_valid <= 1'b1;
            out_data  <= grant_dat;
            out_src   <= grant_idx;
            if (mode)
               rr_ptr <= (grant_idx == SEL_W'(NUM_IN-1)) ? '0 : grant_idx + 1'b1;
         end else begin
            // Drain: data and source keep their last values.
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_nway_reg.sv
module tb_mux_nway_reg;

   localparam int WIDTH  = 16;
   localparam int NUM_IN = 3;
   localparam int SEL_W  = 2;

   typedef struct packed {
      logic [WIDTH-1:0] d;
      logic [SEL_W-1:0] s;
   } exp_t;

   logic                    clk;
   logic                    rst_n;
   logic                    mode;
   logic [SEL_W-1:0]        sel;
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [NUM_IN-1:0]       in_valid;
   logic [NUM_IN-1:0]       in_ready;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_src;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        ch [NUM_IN];

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   assign in_data = {ch[2], ch[1], ch[0]};

   mux_nway_reg #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called just after a falling edge with inputs already driven. Checks the
   // output register against the scoreboard, checks in_ready against the
   // directed expectation, records accepted words, then advances one cycle.
   task automatic step(input string tag, input logic [NUM_IN-1:0] exp_rdy);
      exp_t e;
      #1;
      chk({tag, ":out_valid"}, 32'(out_valid), 32'(sb.size() != 0));
      if (out_valid && sb.size() != 0) begin
         e = sb[0];
         chk({tag, ":out_data"}, 32'(out_data), 32'(e.d));
         chk({tag, ":out_src"}, 32'(out_src), 32'(e.s));
         if (out_ready) void'(sb.pop_front());
      end
      chk({tag, ":in_ready"}, 32'(in_ready), 32'(exp_rdy));
      for (int i = 0; i < NUM_IN; i++) begin
         if (exp_rdy[i]) begin
            e.d = ch[i];
            e.s = SEL_W'(i);
            sb.push_back(e);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = 3'b111; out_ready = 1'b1;
      ch[0] = '0; ch[1] = '0; ch[2] = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset:out_valid", 32'(out_valid), 32'd0);
      chk("reset:out_data", 32'(out_data), 32'd0);
      chk("reset:out_src", 32'(out_src), 32'd0);
      chk("reset:in_ready", 32'(in_ready), 32'd0);
      chk("reset:rr_ptr", 32'(dut.rr_ptr), 32'd0);
      @(negedge clk);

      // Basic latency
      rst_n = 1'b1; mode = 1'b0; sel = 2'd1; in_valid = 3'b010; ch[1] = 16'hBEEF;
      step("basic", 3'b010);
      in_valid = 3'b000;
      step("basic_out", 3'b000);
      step("basic_drain", 3'b000);

      // Fixed-mode clamp of an out-of-range select
      sel = 2'd3; in_valid = 3'b111;
      ch[0] = 16'h1111; ch[1] = 16'h2222; ch[2] = 16'h1234;
      step("clamp", 3'b100);
      in_valid = 3'b000;
      step("clamp_out", 3'b000);

      // Backpressure
      sel = 2'd0; ch[0] = 16'hAAAA; in_valid = 3'b001;
      step("bp_load", 3'b001);
      out_ready = 1'b0; in_valid = 3'b111; ch[0] = 16'hBBBB;
      repeat (4) step("bp_stall", 3'b000);
      out_ready = 1'b1;
      step("bp_release", 3'b001);
      in_valid = 3'b000;
      step("bp_next", 3'b000);
      step("bp_drain", 3'b000);

      // Round-robin fairness
      mode = 1'b1; in_valid = 3'b111;
      ch[0] = 16'hC000; ch[1] = 16'hC001; ch[2] = 16'hC002;
      for (int r = 0; r < 2; r++) begin
         step("rr0", 3'b001);
         step("rr1", 3'b010);
         step("rr2", 3'b100);
      end
      in_valid = 3'b000;
      step("rr_tail", 3'b000);

      // Skip and wrap: park the pointer at 2, then only channel 0 is valid
      in_valid = 3'b010; ch[1] = 16'h5A5A;
      step("wrap_setup", 3'b010);
      chk("wrap:rr_ptr2", 32'(dut.rr_ptr), 32'd2);
      in_valid = 3'b001; ch[0] = 16'h0F0F;
      step("wrap_grant", 3'b001);
      chk("wrap:rr_ptr1", 32'(dut.rr_ptr), 32'd1);
      in_valid = 3'b000;
      step("wrap_out", 3'b000);
      step("wrap_drop", 3'b000);

      // Reset mid-operation with a held word
      in_valid = 3'b100; ch[2] = 16'hDDDD;
      step("mid_load", 3'b100);
      out_ready = 1'b0; in_valid = 3'b111;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst:out_valid", 32'(out_valid), 32'd0);
      chk("midrst:out_data", 32'(out_data), 32'd0);
      chk("midrst:out_src", 32'(out_src), 32'd0);
      chk("midrst:in_ready", 32'(in_ready), 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      ch[0] = 16'hE000; ch[1] = 16'hE001; ch[2] = 16'hE002;
      step("restart0", 3'b001);
      step("restart1", 3'b010);
      in_valid = 3'b000;
      step("restart_tail", 3'b000);
      step("restart_drain", 3'b000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
